// File: rtl/ram_bus_initiator.sv
// Host master for the 4-bit multiplexed RAM bus: SRC frame (skippable by cache) then I/O frame per request.
// rsp_valid 16 clocks after acceptance (8 on cache hit); requests are only taken in phase 7 of idle/IO frames.
module ram_bus_initiator #(
  parameter int unsigned SRC_CACHE = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  output logic       sync,
  output logic       cmd_n,
  output logic [3:0] data_o,
  output logic       data_en,
  input  logic [3:0] data_i,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_chip,
  input  logic [1:0] req_reg,
  input  logic [3:0] req_char,
  input  logic [3:0] req_op,
  input  logic [3:0] req_wdata,
  output logic       rsp_valid,
  output logic [3:0] rsp_rdata
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SRC,
    ST_IO
  } state_t;

  state_t     state;
  logic [2:0] phase;
  logic [2:0] phase_nx;
  logic       chip_q;
  logic [1:0] reg_q;
  logic [3:0] char_q;
  logic [3:0] op_q;
  logic [3:0] wdata_q;
  logic       cache_vld;
  logic [6:0] cache_key;
  logic       accept;
  logic       cache_hit;
  logic       op_wr;
  logic       op_rd;

  assign phase_nx  = phase + 3'd1;
  assign accept    = req_valid && req_ready;
  assign cache_hit = (SRC_CACHE != 0) && cache_vld &&
                     (cache_key == {req_chip, req_reg, req_char});

  always_comb begin
    op_wr = 1'b0;
    op_rd = 1'b0;
    case (op_q)
      4'h0, 4'h1, 4'h4, 4'h5, 4'h6, 4'h7: op_wr = 1'b1;
      4'h8, 4'h9, 4'hB, 4'hC, 4'hD, 4'hE, 4'hF: op_rd = 1'b1;
      default: ;
    endcase
  end

  // Bus outputs are computed one clock ahead from the upcoming phase; state only
  // changes into phase 0, where every frame type leaves the bus idle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      phase     <= 3'd0;
      sync      <= 1'b0;
      cmd_n     <= 1'b1;
      data_o    <= 4'h0;
      data_en   <= 1'b0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 4'h0;
      chip_q    <= 1'b0;
      reg_q     <= 2'd0;
      char_q    <= 4'h0;
      op_q      <= 4'h0;
      wdata_q   <= 4'h0;
      cache_vld <= 1'b0;
      cache_key <= 7'd0;
    end else begin
      phase     <= phase_nx;
      sync      <= (phase_nx == 3'd7);
      req_ready <= (phase_nx == 3'd7) && (state != ST_SRC);
      rsp_valid <= (phase_nx == 3'd7) && (state == ST_IO);
      cmd_n     <= 1'b1;
      data_en   <= 1'b0;
      data_o    <= 4'h0;

      case (state)
        ST_SRC: begin
          if (phase_nx == 3'd6) begin
            cmd_n   <= 1'b0;
            data_en <= 1'b1;
            data_o  <= {1'b0, chip_q, reg_q};
          end else if (phase_nx == 3'd7) begin
            data_en <= 1'b1;
            data_o  <= char_q;
          end
        end
        ST_IO: begin
          if (phase_nx == 3'd4) begin
            cmd_n   <= 1'b0;
            data_en <= 1'b1;
            data_o  <= op_q;
          end else if (phase_nx == 3'd6 && op_wr) begin
            data_en <= 1'b1;
            data_o  <= wdata_q;
          end
        end
        default: ;
      endcase

      if (state == ST_IO && phase == 3'd6) begin
        rsp_rdata <= op_rd ? data_i : 4'h0;
      end

      if (phase == 3'd7) begin
        case (state)
          ST_SRC: begin
            cache_key <= {chip_q, reg_q, char_q};
            cache_vld <= 1'b1;
            state     <= ST_IO;
          end
          default: begin
            if (accept) begin
              chip_q  <= req_chip;
              reg_q   <= req_reg;
              char_q  <= req_char;
              op_q    <= req_op;
              wdata_q <= req_wdata;
              state   <= cache_hit ? ST_IO : ST_SRC;
            end else begin
              state <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_ram_bus_initiator.sv
// Bench for ram_bus_initiator: acts as a p0=0 RAM chip and checks every bus phase against a transaction model.
module tb_ram_bus_initiator;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       sync;
  logic       cmd_n;
  logic [3:0] data_o;
  logic       data_en;
  logic [3:0] data_i;
  logic       req_valid;
  logic       req_ready;
  logic       req_chip;
  logic [1:0] req_reg;
  logic [3:0] req_char;
  logic [3:0] req_op;
  logic [3:0] req_wdata;
  logic       rsp_valid;
  logic [3:0] rsp_rdata;

  int checks = 0;
  int failures = 0;
  int ph = 0;

  bit         cache_vld_m = 1'b0;
  logic [6:0] cache_key_m = 7'd0;
  logic [3:0] last_rsp = 4'h0;
  logic [3:0] mem  [0:3][0:15];
  logic [3:0] stat [0:3][0:3];

  ram_bus_initiator #(.SRC_CACHE(1)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .sync      (sync),
    .cmd_n     (cmd_n),
    .data_o    (data_o),
    .data_en   (data_en),
    .data_i    (data_i),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_chip  (req_chip),
    .req_reg   (req_reg),
    .req_char  (req_char),
    .req_op    (req_op),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata)
  );

  always #5 clock = ~clock;

  // Frame position as seen by the RAM side: restarts at 0 on reset release.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) ph <= 0;
    else          ph <= (ph + 1) % 8;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_quiet_bus(input string tag);
    check({tag, "_cmd_n"}, cmd_n, 1);
    check({tag, "_data_en"}, data_en, 0);
    check({tag, "_data_o"}, data_o, 0);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clock);
      data_i = 4'($urandom);
      check_quiet_bus("idle");
      check("idle_sync", sync, (ph == 7));
      check("idle_ready", req_ready, (ph == 7));
      check("idle_rdata_hold", rsp_rdata, last_rsp);
    end
  endtask

  task automatic do_req(input logic c, input logic [1:0] r, input logic [3:0] ch,
                        input logic [3:0] op, input logic [3:0] wd, input bit abort);
    bit         src, wr, rd, io;
    int         n, nf;
    logic [3:0] rv, erd;
    logic       exp_cmd, exp_en;
    logic [3:0] exp_dat;
    req_chip  = c;
    req_reg   = r;
    req_char  = ch;
    req_op    = op;
    req_wdata = wd;
    req_valid = 1'b1;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin
      @(negedge clock);
      data_i = 4'($urandom);
      n++;
    end
    check("req_accept", req_ready, 1);
    if (req_ready !== 1'b1) begin
      req_valid = 1'b0;
      return;
    end
    check("ready_phase", ph, 7);
    src = !(cache_vld_m && cache_key_m == {c, r, ch});
    wr  = op inside {[4'h0:4'h1], [4'h4:4'h7]};
    rd  = op inside {[4'h8:4'h9], [4'hB:4'hF]};
    // Only chip 0 exists on this bus; a deselected RAM leaves the lines at 0.
    rv  = (c == 1'b0) ? ((op >= 4'hC) ? stat[r][op[1:0]] : mem[r][ch]) : 4'h0;
    erd = rd ? rv : 4'h0;
    @(posedge clock);
    #1;
    req_valid = 1'b0;
    req_chip  = 1'($urandom);
    req_reg   = 2'($urandom);
    req_char  = 4'($urandom);
    req_op    = 4'($urandom);
    req_wdata = 4'($urandom);
    nf = src ? 2 : 1;
    for (int f = 0; f < nf; f++) begin
      io = (f == nf - 1);
      for (int p = 0; p < 8; p++) begin
        @(negedge clock);
        data_i = (io && p == 6 && rd) ? rv : 4'($urandom);
        if (io && p == 5 && abort) begin
          reset_n = 1'b0;
          #1;
          check_quiet_bus("abort");
          check("abort_sync", sync, 0);
          check("abort_ready", req_ready, 0);
          check("abort_rdata", rsp_rdata, 0);
          cache_vld_m = 1'b0;
          last_rsp    = 4'h0;
          repeat (3) begin
            @(negedge clock);
            check_quiet_bus("in_reset");
          end
          reset_n = 1'b1;
          return;
        end
        exp_cmd = 1'b1;
        exp_en  = 1'b0;
        exp_dat = 4'h0;
        if (!io) begin
          if (p == 6) begin
            exp_cmd = 1'b0; exp_en = 1'b1; exp_dat = {1'b0, c, r};
          end else if (p == 7) begin
            exp_en = 1'b1; exp_dat = ch;
          end
        end else if (p == 4) begin
          exp_cmd = 1'b0; exp_en = 1'b1; exp_dat = op;
        end else if (p == 6 && wr) begin
          exp_en = 1'b1; exp_dat = wd;
        end
        check(io ? "io_cmd_n" : "src_cmd_n", cmd_n, exp_cmd);
        check(io ? "io_data_en" : "src_data_en", data_en, exp_en);
        check(io ? "io_data_o" : "src_data_o", data_o, exp_dat);
        check("frame_sync", sync, (p == 7));
        check("rsp_valid", rsp_valid, (io && p == 7));
        check("frame_ready", req_ready, (io && p == 7));
        check("rsp_rdata", rsp_rdata, (io && p == 7) ? erd : last_rsp);
        if (!io && p == 7) begin
          cache_vld_m = 1'b1;
          cache_key_m = {c, r, ch};
        end
      end
    end
    last_rsp = erd;
    if (c == 1'b0) begin
      if (op == 4'h0) mem[r][ch] = wd;
      else if (op inside {[4'h4:4'h7]}) stat[r][op[1:0]] = wd;
    end
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 16; j++) mem[i][j] = 4'h0;
      for (int j = 0; j < 4; j++) stat[i][j] = 4'h0;
    end
    reset_n   = 1'b0;
    data_i    = 4'h0;
    req_valid = 1'b0;
    req_chip  = 1'b0;
    req_reg   = 2'd0;
    req_char  = 4'h0;
    req_op    = 4'h0;
    req_wdata = 4'h0;
    repeat (3) @(negedge clock);
    check_quiet_bus("reset");
    check("reset_sync", sync, 0);
    check("reset_ready", req_ready, 0);
    check("reset_rdata", rsp_rdata, 0);
    reset_n = 1'b1;
    idle(4);

    do_req(1'b0, 2'd2, 4'h5, 4'h0, 4'hA, 1'b0);
    idle(2);
    do_req(1'b0, 2'd2, 4'h5, 4'h8, 4'h0, 1'b0);
    do_req(1'b0, 2'd1, 4'h5, 4'h5, 4'h3, 1'b0);
    do_req(1'b0, 2'd1, 4'h5, 4'hD, 4'h0, 1'b0);
    idle(3);
    do_req(1'b1, 2'd2, 4'h5, 4'h8, 4'h0, 1'b0);
    do_req(1'b1, 2'd2, 4'h5, 4'h0, 4'h7, 1'b0);
    do_req(1'b0, 2'd2, 4'h5, 4'h8, 4'h0, 1'b0);
    idle(1);
    do_req(1'b0, 2'd3, 4'h1, 4'h0, 4'h6, 1'b0);
    do_req(1'b0, 2'd3, 4'h1, 4'h9, 4'h0, 1'b0);
    do_req(1'b0, 2'd3, 4'h2, 4'h6, 4'hC, 1'b0);
    do_req(1'b0, 2'd3, 4'h2, 4'hE, 4'h0, 1'b0);
    do_req(1'b0, 2'd0, 4'h9, 4'h0, 4'h5, 1'b1);
    idle(2);
    do_req(1'b0, 2'd0, 4'h9, 4'h9, 4'h0, 1'b0);

    for (int k = 0; k < 40; k++) begin
      do_req(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 2'($urandom_range(0, 1)),
             4'($urandom_range(0, 2)), 4'($urandom), 4'($urandom),
             ($urandom_range(0, 15) == 0));
      idle($urandom_range(0, 2) == 0 ? $urandom_range(1, 9) : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/ram_bus_initiator.md
Name: ram_bus_initiator

Overview:
- Host-side master for the 4-bit multiplexed RAM-chip bus.
- Turns one request (chip, register, character, I/O opcode, write nibble) into a bus transaction: an SRC frame, then an I/O frame, then returns any read nibble.
- Generates the free-running 8-phase frame, sync, cmd_n and the bus data drive.
- Used by test harnesses and the host bridge to talk to RAM chips without a CPU core.

Parameters:
- SRC_CACHE, 1, when 1 the SRC frame is skipped if chip/reg/char match the last issued SRC.

Ports:
- clock  input  1  system clock
- reset_n  input  1  asynchronous, active-low reset
- sync  output  1  high during phase 7 of every frame
- cmd_n  output  1  active-low command strobe
- data_o  output  4  bus drive value
- data_en  output  1  bus drive enable
- data_i  input  4  bus sample value
- req_valid  input  1  request present
- req_ready  output  1  request accepted when valid&ready
- req_chip  input  1  chip select bit (matches RAM p0)
- req_reg  input  2  RAM register index
- req_char  input  4  character address
- req_op  input  4  I/O opcode low nibble
- req_wdata  input  4  write nibble
- rsp_valid  output  1  one-clock completion pulse
- rsp_rdata  output  4  read nibble (0 for non-reads)

Behaviour:
- Phase counter, 3 bits: 0 on reset, +1 every clock, wraps 7->0. A frame is phases 0..7.
- sync = (phase==7) in every frame, including idle frames.
- State machine: IDLE, SRC, IO.
- State changes happen only at the phase-7 edge.
- While reset_n is low, all outputs are 0 except cmd_n=1; state is IDLE and the cache is invalid.
- req_ready = (phase==7) && (state==IDLE || state==IO).
  - On acceptance, all request fields are captured.
  - Next state is SRC, or IO if SRC_CACHE=1 and the cache is valid with equal chip/reg/char.
  - With no acceptance, IO->IDLE.
- SRC->IO is unconditional.
- SRC frame:
  - phase 6: cmd_n=0, data_en=1, data_o={1'b0, chip, reg}.
  - phase 7: cmd_n=1, data_en=1, data_o=char.
  - At end of phase 7: cache <= {chip, reg, char}, cache valid.
- IO frame, phase 4: cmd_n=0, data_en=1, data_o=op.
- IO frame, phase 6 (cmd_n stays 1):
  - Write ops 0x0, 0x1, 0x4-0x7: data_en=1, data_o=wdata.
  - Read ops 0x8, 0x9, 0xB, 0xC-0xF: data_en=0; data_i captured at end of phase 6.
  - Other ops (0x2, 0x3, 0xA): no drive, rsp_rdata=0.
- IO frame, phase 7:
  - rsp_valid=1 for exactly that clock.
  - rsp_rdata = captured nibble for reads, 0 otherwise; holds until the next rsp_valid.
- All other phases and idle frames: cmd_n=1, data_en=0, data_o=0.
- cmd_n is never low at phase 6 of an IO frame; this keeps RAM selection intact.
- Latency from acceptance (phase 7) to rsp_valid:
  - 16 clocks with SRC.
  - 8 clocks when SRC is skipped.
- Back-to-back: a request accepted in phase 7 of an IO frame starts its frame at the next phase 0, with no idle frame between.
- Requests with req_valid outside phase 7 wait; req fields must be stable until accepted.
- Outputs sync, cmd_n, data_o and data_en are registered or decoded only from phase/state registers; none depends combinationally on req_* or data_i.
- Asynchronous reset mid-transaction aborts immediately: bus released, no rsp_valid, cache invalid.
- The frame restarts at phase 0 when reset_n rises. The RAM side must be reset in the same cycle to stay phase-aligned.

Test Plan:
- Reset, then write req chip0 reg2 char5 op0 wdata 0xA -> bus phase6 cmd_n=0 data 0x2, phase7 data 0x5, next frame phase4 cmd_n=0 data 0x0, phase6 data 0xA; rsp_valid 16 clocks after accept, rdata 0; RAM memory[37]=0xA.
- Read-back same address, op 0x8, SRC_CACHE=1 -> no SRC frame; data_en=0 in phase 6; rsp_valid 8 clocks after accept, rsp_rdata 0xA.
- Status write op 0x5 wdata 0x3 to chip0 reg1, then read op 0xD -> rsp_rdata 0x3; RAM status[5]=0x3.
- Same address requests with chip bit changed (1 vs 0) -> SRC reissued with data 0x4|reg; a RAM with p0=0 ignores the op; read returns 0.
- Four back-to-back requests held valid -> req_ready exactly once per completing IO frame; no idle frame between; rsp_valid once each, in order.
- reset_n low at phase 5 of an IO write -> cmd_n=1, data_en=0 immediately, no rsp_valid; after release the next request performs a full SRC frame (cache invalid).
